membrane_ctrl: RTL and testbench
================================

// Module: membrane_ctrl
// PURPOSE
// Frame-synchronous controller that configures the molecule movers. Debounces player buttons and sequences
// membrane type (none/magenta/red/blue), the membrane raise/lower FSM, and the timed freeze. Drives the
// one-hot membrane flags, membrane_on and freeze consumed by every molecule instance and the renderer.
// PARAMETERS
// DEBOUNCE_FRAMES  3    frames a synced button must stay high before one press event is issued (1..15)
// RAISE_FRAMES     30   frames spent in RAISING or LOWERING (1..255)
// FREEZE_FRAMES    120  freeze duration in frames (1..255)
// PORTS
// clk               in   1  system clock
// reset             in   1  asynchronous, active-high reset
// frame             in   1  one-clk pulse per video frame; all state updates occur only on edges where frame=1
// btnU              in   1  raw button: raise/lower membrane
// btnR              in   1  raw button: cycle membrane type
// btnC              in   1  raw button: start/cancel freeze
// magenta_membrane  out  1  type==MAGENTA
// red_membrane      out  1  type==RED
// blue_membrane     out  1  type==BLUE
// no_membrane       out  1  type==NONE (exactly one of the four type flags is high at all times)
// membrane_on       out  1  high only in state ON
// freeze            out  1  molecules hold position while high
// freeze_left       out  8  frames of freeze remaining (0 when not frozen)
// mem_state         out  2  0=OFF 1=RAISING 2=ON 3=LOWERING
// BEHAVIOUR
// Reset (async, any time incl. mid-raise/mid-freeze): type=NONE (no_membrane=1, other flags 0), mem_state=OFF,
//   membrane_on=0, freeze=0, freeze_left=0, phase counter=0, all debounce counters and press flags cleared.
// All outputs registered; between frame pulses they are constant.
// Input sync: each button passes a 2-flop synchroniser on clk before use.
// Debounce (per button, at each frame pulse): synced=1 -> cnt saturates-increments; synced=0 -> cnt=0.
//   Press flag set at the frame pulse where cnt reaches DEBOUNCE_FRAMES; one flag per press, none while held.
//   Flag consumed (acted on or discarded) at the NEXT frame pulse, then cleared. Latency: press issued at pulse k,
//   effect visible after pulse k+1.
// Type cycle (btnR press): NONE->MAGENTA->RED->BLUE->NONE. Accepted only when mem_state=OFF and freeze=0; else discarded.
// Membrane FSM, phase counter pc (8b), evaluated on frame pulses:
//   OFF: btnU press, type!=NONE, freeze=0 -> RAISING, pc=RAISE_FRAMES-1. btnU with type==NONE discarded.
//   RAISING: freeze=1 -> hold; pc!=0 -> pc-1; pc==0 -> ON. btnU discarded.
//   ON: btnU press, freeze=0 -> LOWERING, pc=RAISE_FRAMES-1.
//   LOWERING: as RAISING, pc==0 -> OFF. btnU discarded.
// Freeze (btnC press): freeze=0 -> freeze=1, freeze_left=FREEZE_FRAMES. freeze=1 -> cancel: freeze=0, freeze_left=0.
//   While frozen, with no btnC press, each frame pulse: freeze_left-1; the pulse where it reaches 0 also clears freeze.
// Simultaneous press flags at one frame pulse: all evaluated against the pre-pulse freeze value; btnU and btnR
//   both valid in OFF -> type advances first, then the btnU check uses the NEW type.
// frame pulses with no pending presses only advance counters; no spurious transitions.
// TESTING
// (bench params DEBOUNCE_FRAMES=2, RAISE_FRAMES=3, FREEZE_FRAMES=4)
// 1 Reset: assert reset mid-RAISING with freeze=1 -> immediately no_membrane=1, mem_state=0, freeze=0, freeze_left=0.
// 2 Debounce: btnR high 1 frame then low -> type unchanged; held 10 frames -> MAGENTA after 3rd pulse, only one step.
// 3 Raise/lower: type=RED, btnU press -> RAISING 3 frames -> ON (membrane_on=1); btnU again -> LOWERING 3 frames -> OFF.
// 4 Freeze: btnC press -> freeze=1, freeze_left 4,3,2,1,0 on successive pulses, freeze=0 with 0; second press mid-way -> immediate 0.
// 5 Freeze pauses FSM: btnC during RAISING pc=1 -> mem_state stays RAISING for 4 frames, ON 2 pulses after release.
// 6 Rejects: btnU with type NONE -> stays OFF; btnR while ON -> type unchanged; btnU+btnR same pulse from NONE -> MAGENTA and RAISING.

Source files
------------

// File: rtl/membrane_ctrl.sv
// Membrane controller: debounced buttons drive the membrane type, raise/lower FSM and timed freeze.
// All state advances only on frame pulses; outputs come straight from registers.
module membrane_ctrl #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int RAISE_FRAMES    = 30,
    parameter int FREEZE_FRAMES   = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic       btnU,
    input  logic       btnR,
    input  logic       btnC,
    output logic       magenta_membrane,
    output logic       red_membrane,
    output logic       blue_membrane,
    output logic       no_membrane,
    output logic       membrane_on,
    output logic       freeze,
    output logic [7:0] freeze_left,
    output logic [1:0] mem_state
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RAISING  = 2'd1,
        ST_ON       = 2'd2,
        ST_LOWERING = 2'd3
    } state_e;

    localparam logic [3:0] DB       = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0] RAISE_PC = 8'(RAISE_FRAMES - 1);
    localparam logic [7:0] FRZ      = 8'(FREEZE_FRAMES);

    // Button index: 0 = U, 1 = R, 2 = C
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0][3:0] cnt_q, cnt_d;
    logic [2:0]      press_q, press_d;
    // One-hot type: [0]=NONE [1]=MAGENTA [2]=RED [3]=BLUE
    logic [3:0]      type_q, type_d;
    state_e          state_q, state_d;
    logic [7:0]      pc_q, pc_d;
    logic [7:0]      left_q, left_d;
    logic            frz_q, frz_d;
    logic            on_q, on_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btnC, btnR, btnU};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        press_d = press_q;
        type_d  = type_q;
        state_d = state_q;
        pc_d    = pc_q;
        left_d  = left_q;
        frz_d   = frz_q;
        on_d    = on_q;
        if (frame) begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i]) begin
                    cnt_d[i] = (cnt_q[i] == DB) ? DB : cnt_q[i] + 4'd1;
                end else begin
                    cnt_d[i] = 4'd0;
                end
                press_d[i] = sync2_q[i] && (cnt_q[i] == DB - 4'd1);
            end

            if (press_q[1] && state_q == ST_OFF && !frz_q) begin
                type_d = {type_q[2:0], type_q[3]};
            end

            // The raise check looks at the already-advanced type
            unique case (state_q)
                ST_OFF: begin
                    if (press_q[0] && !frz_q && !type_d[0]) begin
                        state_d = ST_RAISING;
                        pc_d    = RAISE_PC;
                    end
                end
                ST_ON: begin
                    if (press_q[0] && !frz_q) begin
                        state_d = ST_LOWERING;
                        pc_d    = RAISE_PC;
                    end
                end
                ST_RAISING, ST_LOWERING: begin
                    if (!frz_q) begin
                        if (pc_q != 8'd0) begin
                            pc_d = pc_q - 8'd1;
                        end else begin
                            state_d = (state_q == ST_RAISING) ? ST_ON : ST_OFF;
                        end
                    end
                end
                default: ;
            endcase

            if (press_q[2]) begin
                frz_d  = !frz_q;
                left_d = frz_q ? 8'd0 : FRZ;
            end else if (frz_q) begin
                left_d = left_q - 8'd1;
                if (left_q == 8'd1) begin
                    frz_d = 1'b0;
                end
            end

            on_d = (state_d == ST_ON);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            press_q <= '0;
            type_q  <= 4'b0001;
            state_q <= ST_OFF;
            pc_q    <= '0;
            left_q  <= '0;
            frz_q   <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
            type_q  <= type_d;
            state_q <= state_d;
            pc_q    <= pc_d;
            left_q  <= left_d;
            frz_q   <= frz_d;
            on_q    <= on_d;
        end
    end

    assign no_membrane      = type_q[0];
    assign magenta_membrane = type_q[1];
    assign red_membrane     = type_q[2];
    assign blue_membrane    = type_q[3];
    assign membrane_on      = on_q;
    assign freeze           = frz_q;
    assign freeze_left      = left_q;
    assign mem_state        = state_q;

endmodule

// File: tb/tb_membrane_ctrl.sv
// Directed bench for membrane_ctrl with DEBOUNCE=2, RAISE=3, FREEZE=4.
// Type flags are viewed as {no, magenta, red, blue}.
module tb_membrane_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame = 1'b0;
    logic       btnU = 1'b0;
    logic       btnR = 1'b0;
    logic       btnC = 1'b0;
    logic       magenta_membrane, red_membrane, blue_membrane, no_membrane;
    logic       membrane_on, freeze;
    logic [7:0] freeze_left;
    logic [1:0] mem_state;

    int checks = 0;
    int failures = 0;

    localparam logic [3:0] T_NONE = 4'b1000;
    localparam logic [3:0] T_MAG  = 4'b0100;
    localparam logic [3:0] T_RED  = 4'b0010;
    localparam logic [3:0] T_BLUE = 4'b0001;

    wire [3:0] tflags = {no_membrane, magenta_membrane, red_membrane, blue_membrane};

    membrane_ctrl #(
        .DEBOUNCE_FRAMES(2),
        .RAISE_FRAMES(3),
        .FREEZE_FRAMES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame(frame),
        .btnU(btnU),
        .btnR(btnR),
        .btnC(btnC),
        .magenta_membrane(magenta_membrane),
        .red_membrane(red_membrane),
        .blue_membrane(blue_membrane),
        .no_membrane(no_membrane),
        .membrane_on(membrane_on),
        .freeze(freeze),
        .freeze_left(freeze_left),
        .mem_state(mem_state)
    );

    always #5 clk = ~clk;

    task automatic frames(input int n);
        repeat (n) begin
            repeat (3) @(negedge clk);
            frame = 1'b1;
            @(negedge clk);
            frame = 1'b0;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btnU = v;
            1: btnR = v;
            default: btnC = v;
        endcase
    endtask

    // Hold for exactly DEBOUNCE pulses: the flag is pending afterwards
    task automatic press_btn(input int b);
        set_btn(b, 1'b1);
        frames(2);
        set_btn(b, 1'b0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if ({tflags, mem_state, membrane_on, freeze, freeze_left} !== {T_NONE, 2'd0, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_init got=%h exp=%h", {tflags, mem_state, membrane_on, freeze, freeze_left},
                     {T_NONE, 2'd0, 1'b0, 1'b0, 8'd0});
        end
        @(negedge clk);
        reset = 1'b0;
        frames(2);
        checks++;
        if ({tflags, mem_state} !== {T_NONE, 2'd0}) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=%h", {tflags, mem_state}, {T_NONE, 2'd0});
        end
    endtask

    task automatic test_debounce;
        btnR = 1'b1;
        frames(1);
        btnR = 1'b0;
        frames(3);
        checks++;
        if (tflags !== T_NONE) begin
            failures++;
            $display("FAIL debounce_short got=%b exp=%b", tflags, T_NONE);
        end
        btnR = 1'b1;
        frames(2);
        checks++;
        if (tflags !== T_NONE) begin
            failures++;
            $display("FAIL debounce_pending got=%b exp=%b", tflags, T_NONE);
        end
        frames(1);
        checks++;
        if (tflags !== T_MAG) begin
            failures++;
            $display("FAIL debounce_third got=%b exp=%b", tflags, T_MAG);
        end
        frames(7);
        btnR = 1'b0;
        frames(1);
        checks++;
        if (tflags !== T_MAG) begin
            failures++;
            $display("FAIL debounce_held got=%b exp=%b", tflags, T_MAG);
        end
    endtask

    task automatic test_raise_lower;
        press_btn(1);
        frames(1);
        checks++;
        if (tflags !== T_RED) begin
            failures++;
            $display("FAIL type_red got=%b exp=%b", tflags, T_RED);
        end
        press_btn(0);
        checks++;
        if (mem_state !== 2'd0) begin
            failures++;
            $display("FAIL raise_pending got=%0d exp=0", mem_state);
        end
        for (int i = 0; i < 3; i++) begin
            frames(1);
            checks++;
            if ({mem_state, membrane_on} !== {2'd1, 1'b0}) begin
                failures++;
                $display("FAIL raising_%0d got=%b exp=%b", i, {mem_state, membrane_on}, 3'b010);
            end
        end
        frames(1);
        checks++;
        if ({mem_state, membrane_on} !== {2'd2, 1'b1}) begin
            failures++;
            $display("FAIL on got=%b exp=%b", {mem_state, membrane_on}, 3'b101);
        end
        press_btn(0);
        for (int i = 0; i < 3; i++) begin
            frames(1);
            checks++;
            if ({mem_state, membrane_on} !== {2'd3, 1'b0}) begin
                failures++;
                $display("FAIL lowering_%0d got=%b exp=%b", i, {mem_state, membrane_on}, 3'b110);
            end
        end
        frames(1);
        checks++;
        if ({mem_state, membrane_on, tflags} !== {2'd0, 1'b0, T_RED}) begin
            failures++;
            $display("FAIL off got=%b exp=%b", {mem_state, membrane_on, tflags}, {2'd0, 1'b0, T_RED});
        end
    endtask

    task automatic test_freeze;
        logic [7:0] exp_left;
        press_btn(2);
        frames(1);
        checks++;
        if ({freeze, freeze_left} !== {1'b1, 8'd4}) begin
            failures++;
            $display("FAIL freeze_start got=%0d/%0d exp=1/4", freeze, freeze_left);
        end
        for (int i = 3; i >= 0; i--) begin
            frames(1);
            exp_left = 8'(i);
            checks++;
            if ({freeze, freeze_left} !== {(i != 0), exp_left}) begin
                failures++;
                $display("FAIL freeze_count_%0d got=%0d/%0d exp=%0d/%0d", i, freeze, freeze_left,
                         (i != 0), exp_left);
            end
        end
        press_btn(2);
        frames(1);
        press_btn(2);
        checks++;
        if ({freeze, freeze_left} !== {1'b1, 8'd2}) begin
            failures++;
            $display("FAIL freeze_mid got=%0d/%0d exp=1/2", freeze, freeze_left);
        end
        frames(1);
        checks++;
        if ({freeze, freeze_left} !== {1'b0, 8'd0}) begin
            failures++;
            $display("FAIL freeze_cancel got=%0d/%0d exp=0/0", freeze, freeze_left);
        end
    endtask

    task automatic test_freeze_pauses_fsm;
        btnU = 1'b1;
        frames(1);
        btnC = 1'b1;
        frames(1);
        btnU = 1'b0;
        frames(1);
        btnC = 1'b0;
        frames(1);
        checks++;
        if ({mem_state, freeze, freeze_left} !== {2'd1, 1'b1, 8'd4}) begin
            failures++;
            $display("FAIL pause_start got=%h exp=%h", {mem_state, freeze, freeze_left}, {2'd1, 1'b1, 8'd4});
        end
        for (int i = 0; i < 4; i++) begin
            frames(1);
            checks++;
            if (mem_state !== 2'd1) begin
                failures++;
                $display("FAIL pause_hold_%0d got=%0d exp=1", i, mem_state);
            end
        end
        checks++;
        if (freeze !== 1'b0) begin
            failures++;
            $display("FAIL pause_release got=%0d exp=0", freeze);
        end
        frames(1);
        checks++;
        if (mem_state !== 2'd1) begin
            failures++;
            $display("FAIL pause_last got=%0d exp=1", mem_state);
        end
        frames(1);
        checks++;
        if ({mem_state, membrane_on} !== {2'd2, 1'b1}) begin
            failures++;
            $display("FAIL pause_on got=%b exp=101", {mem_state, membrane_on});
        end
        press_btn(0);
        frames(4);
        checks++;
        if (mem_state !== 2'd0) begin
            failures++;
            $display("FAIL pause_back_off got=%0d exp=0", mem_state);
        end
    endtask

    task automatic test_rejects;
        press_btn(1);
        frames(1);
        checks++;
        if (tflags !== T_BLUE) begin
            failures++;
            $display("FAIL type_blue got=%b exp=%b", tflags, T_BLUE);
        end
        press_btn(1);
        frames(1);
        checks++;
        if (tflags !== T_NONE) begin
            failures++;
            $display("FAIL type_wrap got=%b exp=%b", tflags, T_NONE);
        end
        press_btn(0);
        frames(1);
        checks++;
        if (mem_state !== 2'd0) begin
            failures++;
            $display("FAIL reject_none got=%0d exp=0", mem_state);
        end
        btnU = 1'b1;
        btnR = 1'b1;
        frames(2);
        btnU = 1'b0;
        btnR = 1'b0;
        frames(1);
        checks++;
        if ({tflags, mem_state} !== {T_MAG, 2'd1}) begin
            failures++;
            $display("FAIL combo_press got=%b exp=%b", {tflags, mem_state}, {T_MAG, 2'd1});
        end
        frames(3);
        press_btn(1);
        frames(1);
        checks++;
        if ({tflags, mem_state} !== {T_MAG, 2'd2}) begin
            failures++;
            $display("FAIL reject_type_on got=%b exp=%b", {tflags, mem_state}, {T_MAG, 2'd2});
        end
    endtask

    task automatic test_reset_mid;
        press_btn(0);
        frames(4);
        btnU = 1'b1;
        btnC = 1'b1;
        frames(2);
        btnU = 1'b0;
        btnC = 1'b0;
        frames(1);
        checks++;
        if ({mem_state, freeze, freeze_left} !== {2'd1, 1'b1, 8'd4}) begin
            failures++;
            $display("FAIL prereset got=%h exp=%h", {mem_state, freeze, freeze_left}, {2'd1, 1'b1, 8'd4});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({tflags, mem_state, membrane_on, freeze, freeze_left} !== {T_NONE, 2'd0, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", {tflags, mem_state, membrane_on, freeze, freeze_left},
                     {T_NONE, 2'd0, 1'b0, 1'b0, 8'd0});
        end
        @(negedge clk);
        reset = 1'b0;
        frames(3);
        checks++;
        if ({tflags, mem_state, freeze} !== {T_NONE, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL post_reset got=%b exp=%b", {tflags, mem_state, freeze}, {T_NONE, 3'b000});
        end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_raise_lower;
        test_freeze;
        test_freeze_pauses_fsm;
        test_rejects;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
